// File: rtl/sopc_multi_timer.sv
`default_nettype none
// sopc_multi_timer: NUM_CH-channel Avalon-MM interval timer (16-bit bus, 8 regs/channel), rev 1.0.
// Optional per-channel PWM compare output enabled by defining MULTI_TIMER_PWM_EN.
module sopc_multi_timer #(
    parameter int NUM_CH       = 4,
    parameter int COUNTER_W    = 32,
    parameter int PRESCALE_W   = 16,
    parameter int RESET_PERIOD = 49999
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [5:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec,
    output logic [NUM_CH-1:0] pwm_out
);
    localparam int                   HI_W       = COUNTER_W - 16;
    localparam logic [COUNTER_W-1:0] RST_PERIOD = COUNTER_W'(RESET_PERIOD);

    logic        wr;
    logic [2:0]  ch_sel;
    logic [2:0]  reg_sel;
    logic [15:0] ch_rd [NUM_CH];
    logic [15:0] rd_next;

    assign wr      = chipselect & ~write_n;
    assign ch_sel  = address[5:3];
    assign reg_sel = address[2:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [COUNTER_W-1:0]  counter;
        logic [COUNTER_W-1:0]  period;
        logic [COUNTER_W-1:0]  period_next;
        logic [COUNTER_W-1:0]  snap;
        logic [PRESCALE_W-1:0] prescale;
        logic [PRESCALE_W-1:0] div;
        logic                  run;
        logic                  to;
        logic                  ito;
        logic                  cont;
        logic                  sel;
        logic                  tick;
        logic                  expire;
        logic                  period_wr;
        logic                  ctrl_wr;
        logic                  start;
        logic                  stop;
        logic [15:0]           cmp_rd;
        logic [15:0]           rd;

        assign sel       = wr && (ch_sel == 3'(i));
        assign period_wr = sel && (reg_sel == 3'd2 || reg_sel == 3'd3);
        assign ctrl_wr   = sel && (reg_sel == 3'd1);
        assign start     = ctrl_wr && writedata[2];
        assign stop      = ctrl_wr && writedata[3];
        // >= keeps the divider from running away if prescale shrinks mid-count
        assign tick      = run && (div >= prescale);
        assign expire    = tick && (counter == '0);

        always_comb begin
            period_next = period;
            if (sel && reg_sel == 3'd2)
                period_next[15:0] = writedata;
            if (sel && reg_sel == 3'd3)
                period_next[COUNTER_W-1:16] = writedata[HI_W-1:0];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                counter  <= RST_PERIOD;
                period   <= RST_PERIOD;
                snap     <= '0;
                prescale <= '0;
                div      <= '0;
                run      <= 1'b0;
                to       <= 1'b0;
                ito      <= 1'b0;
                cont     <= 1'b0;
            end else begin
                period <= period_next;

                if (period_wr || start || !run || tick)
                    div <= '0;
                else
                    div <= div + 1'b1;

                if (period_wr)
                    counter <= period_next;
                else if (tick)
                    counter <= (counter == '0) ? period : counter - 1'b1;

                if (period_wr)
                    run <= 1'b0;
                else if (start)
                    run <= 1'b1;
                else if (stop)
                    run <= 1'b0;
                else if (expire)
                    run <= cont;

                // a timeout in the same cycle as a status write must not be lost
                if (expire)
                    to <= 1'b1;
                else if (sel && reg_sel == 3'd0)
                    to <= 1'b0;

                if (ctrl_wr) begin
                    ito  <= writedata[0];
                    cont <= writedata[1];
                end

                if (sel && (reg_sel == 3'd4 || reg_sel == 3'd5))
                    snap <= counter;

                if (sel && reg_sel == 3'd6)
                    prescale <= writedata[PRESCALE_W-1:0];
            end
        end

`ifdef MULTI_TIMER_PWM_EN
        logic [15:0] compare;
        logic        pwm;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                compare <= '0;
                pwm     <= 1'b0;
            end else begin
                if (sel && reg_sel == 3'd7)
                    compare <= writedata;
                pwm <= run && (counter < COUNTER_W'(compare));
            end
        end

        assign cmp_rd     = compare;
        assign pwm_out[i] = pwm;
`else
        assign cmp_rd     = '0;
        assign pwm_out[i] = 1'b0;
`endif

        always_comb begin
            rd = '0;
            case (reg_sel)
                3'd0: rd = {14'b0, run, to};
                3'd1: rd = {14'b0, cont, ito};
                3'd2: rd = period[15:0];
                3'd3: rd = 16'(period[COUNTER_W-1:16]);
                3'd4: rd = snap[15:0];
                3'd5: rd = 16'(snap[COUNTER_W-1:16]);
                3'd6: rd = 16'(prescale);
                3'd7: rd = cmp_rd;
            endcase
        end

        assign ch_rd[i]   = rd;
        assign irq_vec[i] = to & ito;
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_sel == 3'(i))
                rd_next = ch_rd[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd_next;
    end

    assign irq = |irq_vec;

endmodule
`default_nettype wire

// File: doc/sopc_multi_timer.md
Name: sopc_multi_timer

Overview:
- Multi-channel Avalon-MM interval timer with per-channel prescaler and a combined interrupt, for SOPC video systems that need several independent time bases (frame tick, watchdog, delays).
- Each channel has a down-counter with one-shot and continuous modes, a snapshot register, and a timeout flag.
- Uses a 16-bit slave data bus, one 8-word register window per channel, and registered read data with one cycle of latency.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
COUNTER_W, 32, counter and period width in bits (17..32)
PRESCALE_W, 16, prescaler register width (1..16)
RESET_PERIOD, 49999, reset value of period and counter (1 ms at 50 MHz)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  6  {channel[5:3], reg[2:0]}
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data
irq  out  1  OR of irq_vec
irq_vec  out  NUM_CH  per-channel interrupt (TO & ITO)
pwm_out  out  NUM_CH  per-channel PWM output (see Optional Feature)

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All state resets asynchronously; every other change happens on the rising edge of clk.
- Write strobe: wr = chipselect & ~write_n.
- Channels with index ≥ NUM_CH read as 0; writes to them are ignored.
- Register map, per channel:
  - reg 0, status: read {14'b0, RUN, TO}; any write clears TO.
  - reg 1, control: bit0 ITO, bit1 CONT (stored); bit2 START, bit3 STOP (write-only strobes). Reads {14'b0, CONT, ITO}.
  - reg 2, period_l: period[15:0].
  - reg 3, period_h: period[COUNTER_W-1:16]. Unused upper bits read 0.
  - reg 4 / reg 5: snap_l / snap_h. A write to either copies the live counter into the snapshot; reads return the snapshot halves.
  - reg 6, prescale: PRESCALE_W bits, zero-extended on read.
  - reg 7: compare value (Optional Feature); reads 0 when the feature is compiled out.
- Reset values:
  - counter = period = RESET_PERIOD; prescale = 0; snapshot = 0.
  - RUN = TO = ITO = CONT = 0.
  - readdata = 0; irq = 0; irq_vec = 0; pwm_out = 0.
- Prescaler:
  - A per-channel divider counts while RUN = 1 and produces a tick every prescale+1 clocks. Prescale = 0 gives a tick every clock.
  - The divider is cleared on START, on any period write, and while RUN = 0.
- Counting, on each tick:
  - If counter ≠ 0: counter decrements by 1.
  - If counter = 0: counter reloads to period, TO is set, and RUN takes the value of CONT.
  - Timeout period is (period+1)·(prescale+1) clocks.
- Period write (reg 2 or 3): the next cycle forces counter to the new period and clears RUN and the divider. The other half of period is unchanged.
- Control write: CONT and ITO update from writedata. START sets RUN; STOP clears RUN; if both are set, START wins. A stopped counter holds its value, and START resumes from it.
- Simultaneous status write and timeout on the same cycle: TO ends up 1 (set wins).
- Snapshot capture and a tick on the same cycle: the snapshot takes the pre-tick counter value.
- Interrupts: irq_vec[i] = TO[i] & ITO[i], combinational from registers. irq = |irq_vec.
- Read data: readdata is updated every clock from the address mux, regardless of chipselect, so data appears one cycle after address.
- Mid-operation reset: all channels return to the reset values immediately; there is no pending state.

Optional Feature:
- Macro MULTI_TIMER_PWM_EN.
- Defined:
  - reg 7 is a per-channel 16-bit compare register, reset 0.
  - pwm_out[i] is registered and equals RUN[i] & (counter[i] < zero-extended compare[i]). It updates one clock after the counter.
- Undefined:
  - No compare storage; reg 7 reads 0 and writes are ignored.
  - pwm_out is tied to 0.

Test Plan:
- Reset, then read ch0 reg 2 / reg 3 / reg 0 → 0xC34F / 0x0000 / 0x0000. irq = 0.
- Ch1: period = 9, prescale = 0, control write 0x7 (START | CONT | ITO) → TO sets and irq_vec[1] = irq = 1 every 10 clocks. Write reg 0 → TO clears. It sets again 10 clocks after the previous timeout.
- Ch2: period = 4, prescale = 2, control write 0x4 (one-shot) → TO sets after 15 clocks. RUN = 0 afterwards; counter reads back 4 via snapshot; irq stays 0 (ITO = 0).
- Ch0 running, control write 0xC (START and STOP together) → RUN = 1. Control write 0x8 → counter frozen; two snapshots 20 clocks apart are equal.
- Status write on the exact cycle ch1 times out → TO = 1 afterwards. Write to channel 7 when NUM_CH = 4 → no state change; reads return 0.
- With MULTI_TIMER_PWM_EN: period = 99, compare = 25, continuous → pwm_out high 25 of every 100 clocks. Without the macro → pwm_out = 0 and reg 7 reads 0.
